alu_pwr_seq: RTL and testbench

- Power-sequencing controller for the power-gated ALU domain; sits in the always-on domain between system power-management requests and the ALU.
- Generates the ALU power enable, isolation enable and domain reset in a safe order.
- Drains in-flight ALU work before power-down and gates new operation starts while the ALU is not fully up.

---
 rtl/alu_pwr_pkg.sv | 27 ++
 rtl/alu_pwr_dwell_cnt.sv | 35 +++
 rtl/alu_pwr_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_pwr_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_pkg.sv
// Shared types and defaults for the ALU power-sequencing controller.
package alu_pwr_pkg;

    localparam int unsigned ST_W  = 3;
    localparam int unsigned CNT_W = 8;

    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned RST_CYCLES_DEF    = 2;
    localparam int unsigned IDLE_TIMEOUT_DEF  = 64;

    typedef enum logic [ST_W-1:0] {
        StOff     = 3'd0,
        StPwrUp   = 3'd1,
        StRstHold = 3'd2,
        StUniso   = 3'd3,
        StOn      = 3'd4,
        StDrain   = 3'd5,
        StIso     = 3'd6,
        StPwrDn   = 3'd7
    } alu_pwr_state_t;

    // Dwell counter load value: a state held N cycles exits when the counter hits 0.
    function automatic logic [CNT_W-1:0] dwell_load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/alu_pwr_dwell_cnt.sv
// Loadable down-counter with zero flag; shared by the settle and reset dwell states.
module alu_pwr_dwell_cnt
    import alu_pwr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load takes priority; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Power-sequencing controller for the power-gated ALU domain.
// Optional idle auto-sleep is enabled by defining ALU_PWR_SEQ_AUTO_SLEEP_EN.
module alu_pwr_seq
    import alu_pwr_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
    parameter int unsigned IDLE_TIMEOUT  = IDLE_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sleep_req,
    input  logic            wake_req,
    input  logic            start_in,
    input  logic            alu_busy,
    output logic            start_out,
    output logic            alu_pwr_en,
    output logic            iso_en,
    output logic            alu_rst_n,
    output logic            alu_ready,
    output logic            sleep_ack,
    output logic            wake_ack,
    output logic [ST_W-1:0] state_o
);

    alu_pwr_state_t   state_q, state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic             auto_sleep;
    logic             pwr_d, iso_d, rstn_d;

    alu_pwr_dwell_cnt u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

`ifdef ALU_PWR_SEQ_AUTO_SLEEP_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;

    // Count idle ON cycles; any activity or leaving ON clears the count.
    always_comb begin
        idle_cnt_d = '0;
        auto_sleep = 1'b0;
        if (state_q == StOn && !start_in && !alu_busy) begin
            idle_cnt_d = (idle_cnt_q == 16'hffff) ? idle_cnt_q : idle_cnt_q + 16'd1;
            auto_sleep = (32'(idle_cnt_d) >= IDLE_TIMEOUT);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign auto_sleep = 1'b0;
`endif

    // Next-state logic; requests are only sampled in OFF and ON.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            StOff: begin
                if (wake_req) begin
                    state_d      = StPwrUp;
                    cnt_load     = 1'b1;
                    cnt_load_val = dwell_load(SETTLE_CYCLES);
                end
            end
            StPwrUp: begin
                if (cnt_zero) begin
                    state_d      = StRstHold;
                    cnt_load     = 1'b1;
                    cnt_load_val = dwell_load(RST_CYCLES);
                end
            end
            StRstHold: begin
                if (cnt_zero) begin
                    state_d = StUniso;
                end
            end
            StUniso: state_d = StOn;
            StOn: begin
                // Wake wins over both sleep sources.
                if (!wake_req && (sleep_req || auto_sleep)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!alu_busy) begin
                    state_d = StIso;
                end
            end
            StIso: begin
                state_d      = StPwrDn;
                cnt_load     = 1'b1;
                cnt_load_val = dwell_load(SETTLE_CYCLES);
            end
            StPwrDn: begin
                if (cnt_zero) begin
                    state_d = StOff;
                end
            end
            default: state_d = StOff;
        endcase
    end

    // Power/isolation/reset decode of the upcoming state.
    always_comb begin
        pwr_d  = 1'b1;
        iso_d  = 1'b1;
        rstn_d = 1'b1;
        case (state_d)
            StOff:     begin pwr_d = 1'b0; iso_d = 1'b1; rstn_d = 1'b0; end
            StPwrUp:   begin pwr_d = 1'b1; iso_d = 1'b1; rstn_d = 1'b0; end
            StRstHold: begin pwr_d = 1'b1; iso_d = 1'b1; rstn_d = 1'b0; end
            StUniso:   begin pwr_d = 1'b1; iso_d = 1'b1; rstn_d = 1'b1; end
            StOn:      begin pwr_d = 1'b1; iso_d = 1'b0; rstn_d = 1'b1; end
            StDrain:   begin pwr_d = 1'b1; iso_d = 1'b0; rstn_d = 1'b1; end
            StIso:     begin pwr_d = 1'b1; iso_d = 1'b1; rstn_d = 1'b1; end
            StPwrDn:   begin pwr_d = 1'b0; iso_d = 1'b1; rstn_d = 1'b0; end
            default:   begin pwr_d = 1'b0; iso_d = 1'b1; rstn_d = 1'b0; end
        endcase
    end

    // State and registered outputs; reset aborts any sequence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOff;
            alu_pwr_en <= 1'b0;
            iso_en     <= 1'b1;
            alu_rst_n  <= 1'b0;
            alu_ready  <= 1'b0;
            wake_ack   <= 1'b0;
            sleep_ack  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_pwr_en <= pwr_d;
            iso_en     <= iso_d;
            alu_rst_n  <= rstn_d;
            alu_ready  <= (state_d == StOn);
            wake_ack   <= (state_d == StOn) && (state_q != StOn);
            sleep_ack  <= (state_d == StOff) && (state_q == StPwrDn);
        end
    end

    assign state_o   = state_q;
    assign start_out = start_in & (state_q == StOn);

`ifndef SYNTHESIS
    a_param_range: assert property (@(posedge clk)
        (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 255) &&
        (RST_CYCLES >= 1) && (RST_CYCLES <= 255) &&
        (IDLE_TIMEOUT >= 1) && (IDLE_TIMEOUT <= 65535));

    a_iso_when_down: assert property (@(posedge clk) disable iff (!rst_n)
        (!alu_pwr_en || !alu_rst_n) |-> iso_en);

    a_no_pwr_on_unclamp: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(iso_en) |-> $stable(alu_pwr_en));
`endif

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Self-checking bench for alu_pwr_seq: queue-based schedule model plus directed literals.
module tb_alu_pwr_seq;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned RSTC   = 2;
`ifdef ALU_PWR_SEQ_AUTO_SLEEP_EN
    localparam int unsigned IDLE_TO = 8;
`else
    localparam int unsigned IDLE_TO = 64;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sleep_req, wake_req, start_in, alu_busy;
    logic       start_out, alu_pwr_en, iso_en, alu_rst_n, alu_ready, sleep_ack, wake_ack;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    alu_pwr_seq #(
        .SETTLE_CYCLES (SETTLE),
        .RST_CYCLES    (RSTC),
        .IDLE_TIMEOUT  (IDLE_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sleep_req  (sleep_req),
        .wake_req   (wake_req),
        .start_in   (start_in),
        .alu_busy   (alu_busy),
        .start_out  (start_out),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .alu_rst_n  (alu_rst_n),
        .alu_ready  (alu_ready),
        .sleep_ack  (sleep_ack),
        .wake_ack   (wake_ack),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: current state number plus a queue of scheduled future states.
    int m_st, m_prev, m_idle;
    int m_plan[$];
    logic m_wack, m_sack;
    int pwr_tab[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int iso_tab[8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    int rst_tab[8] = '{0, 0, 0, 1, 1, 1, 1, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_prev = 0; m_idle = 0; m_wack = 0; m_sack = 0;
            m_plan.delete();
        end else begin
            bit idle_hit;
            idle_hit = 0;
            m_prev = m_st;
            if (m_plan.size() > 0) begin
                m_st = m_plan.pop_front();
            end else if (m_st == 0) begin
                if (wake_req) begin
                    m_st = 1;
                    for (int i = 1; i < SETTLE; i++) m_plan.push_back(1);
                    for (int i = 0; i < RSTC; i++) m_plan.push_back(2);
                    m_plan.push_back(3);
                    m_plan.push_back(4);
                end
            end else if (m_st == 4) begin
                if (start_in || alu_busy) m_idle = 0;
                else m_idle++;
`ifdef ALU_PWR_SEQ_AUTO_SLEEP_EN
                idle_hit = (m_idle >= IDLE_TO);
`endif
                if (!wake_req && (sleep_req || idle_hit)) m_st = 5;
            end else if (m_st == 5) begin
                if (!alu_busy) begin
                    m_st = 6;
                    for (int i = 0; i < SETTLE; i++) m_plan.push_back(7);
                    m_plan.push_back(0);
                end
            end
            if (m_st != 4) m_idle = 0;
            m_wack = (m_st == 4) && (m_prev != 4);
            m_sack = (m_st == 0) && (m_prev == 7);
        end
    end

    // Per-cycle comparison against the model, plus event counters for directed checks.
    bit   cmp_en = 0;
    int   cnt_st[8];
    int   sack_cnt;
    logic prev_pwr_s = 1'b0, prev_iso_s = 1'b1;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_state", 32'(state_o), 32'(m_st));
            chk("m_pwr", 32'(alu_pwr_en), 32'(pwr_tab[m_st]));
            chk("m_iso", 32'(iso_en), 32'(iso_tab[m_st]));
            chk("m_rstn", 32'(alu_rst_n), 32'(rst_tab[m_st]));
            chk("m_ready", 32'(alu_ready), 32'(m_st == 4));
            chk("m_wack", 32'(wake_ack), 32'(m_wack));
            chk("m_sack", 32'(sleep_ack), 32'(m_sack));
            chk("m_start", 32'(start_out), 32'(start_in && m_st == 4));
            if (prev_pwr_s && !alu_pwr_en) chk("pwr_off_order", 32'(prev_iso_s), 32'd1);
            cnt_st[state_o]++;
            if (sleep_ack) sack_cnt++;
            prev_pwr_s = alu_pwr_en;
            prev_iso_s = iso_en;
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0; sleep_req = 0; wake_req = 0; start_in = 1; alu_busy = 0;
        repeat (2) step();
        // Reset state
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_pwr", 32'(alu_pwr_en), 32'd0);
        chk("rst_iso", 32'(iso_en), 32'd1);
        chk("rst_rstn", 32'(alu_rst_n), 32'd0);
        chk("rst_ready", 32'(alu_ready), 32'd0);
        chk("rst_start", 32'(start_out), 32'd0);
        chk("rst_acks", 32'({wake_ack, sleep_ack}), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1;
        repeat (2) step();

        // Power-up with start_in held high: literal timing from wake at cycle T
        wake_req = 1;
        step();
        wake_req = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("pu_pwr", 32'(alu_pwr_en), 32'd1);
            chk("pu_rstn", 32'(alu_rst_n), 32'(k >= 7));
            chk("pu_iso", 32'(iso_en), 32'(k < 8));
            chk("pu_ready", 32'(alu_ready), 32'(k >= 8));
            chk("pu_wack", 32'(wake_ack), 32'(k == 8));
            chk("pu_start", 32'(start_out), 32'(k >= 8));
        end
        step(); start_in = 0;
        step(); start_in = 1;
        step();

        // Drain: busy for 10 cycles, start_in must be dropped throughout
        for (int i = 0; i < 8; i++) cnt_st[i] = 0;
        sack_cnt = 0;
        sleep_req = 1; alu_busy = 1;
        step();
        sleep_req = 0;
        repeat (9) step();
        alu_busy = 0; start_in = 0;
        repeat (12) step();
        @(negedge clk);
        chk("drain_cycles", 32'(cnt_st[5]), 32'd10);
        chk("iso_cycles", 32'(cnt_st[6]), 32'd1);
        chk("pwrdn_cycles", 32'(cnt_st[7]), 32'd4);
        chk("sleep_ack_cnt", 32'(sack_cnt), 32'd1);
        chk("drain_end_off", 32'(state_o), 32'd0);

        // Simultaneous requests in ON then in OFF
        step();
        start_in = 1; wake_req = 1;
        step();
        wake_req = 0;
        repeat (10) step();
        start_in = 0; sleep_req = 1; wake_req = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("both_on", 32'(state_o), 32'd4);
        end
        step();
        wake_req = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state_o == 3'd0) break;
        end
        chk("reach_off", 32'(state_o), 32'd0);
        step();
        wake_req = 1;
        step();
        wake_req = 0; sleep_req = 0;
        @(negedge clk);
        chk("both_off_pwrup", 32'(state_o), 32'd1);

        // Reset during RST_HOLD aborts immediately
        repeat (4) step();
        chk("pre_rst_hold", 32'(state_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_pwr", 32'(alu_pwr_en), 32'd0);
        chk("abort_iso", 32'(iso_en), 32'd1);
        chk("abort_rstn", 32'(alu_rst_n), 32'd0);
        chk("abort_ready", 32'(alu_ready), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Idle in ON with a start pulse at idle cycle 5
        start_in = 1; wake_req = 1;
        step();
        wake_req = 0;
        repeat (10) step();
        start_in = 0;
        repeat (4) step();
        start_in = 1;
        step();
        start_in = 0;
        repeat (3) step();
        @(negedge clk);
        chk("idle_restart_on", 32'(state_o), 32'd4);
        repeat (4) step();
        @(negedge clk);
        chk("idle_pre_timeout", 32'(state_o), 32'd4);
        step();
        @(negedge clk);
`ifdef ALU_PWR_SEQ_AUTO_SLEEP_EN
        chk("auto_sleep_drain", 32'(state_o), 32'd5);
        repeat (10) step();
`else
        chk("no_auto_sleep", 32'(state_o), 32'd4);
        repeat (80) step();
        @(negedge clk);
        chk("stay_on_long", 32'(state_o), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
